// File: rtl/timer_digit_loader.sv
// rtl/timer_digit_loader.sv - keypad M:SS digit collector driving the countdown timer load strobe
// Optional: define TIMER_NORMALIZE_EN to fold tens-of-seconds overflow into minutes on start.
module timer_digit_loader #(
  parameter logic [3:0] MAX_TENS    = 4'd5,
  parameter int         LOAD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_cancel,
  input  logic       key_start,
  input  logic       timer_running,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       load,
  output logic [1:0] digit_count,
  output logic       loaded,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, DONE} state_t;

  state_t     state;
  logic [1:0] load_cnt;

  logic digit_ok;
  logic start_req;
  logic nonzero;
  logic tens_ok;

  assign digit_ok  = key_valid && (key_digit <= 4'd9) && !timer_running;
  // Any key_valid in the same cycle wins over start, even a dropped digit.
  assign start_req = key_start && !key_valid && !timer_running;
  assign nonzero   = |{min_ones, sec_tens, sec_ones};
  assign tens_ok   = sec_tens <= MAX_TENS;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      load_cnt    <= 2'd0;
      sec_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      min_ones    <= 4'd0;
      digit_count <= 2'd0;
      load        <= 1'b1;
      loaded      <= 1'b0;
      err         <= 1'b0;
    end else begin
      loaded <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (digit_ok) begin
            min_ones    <= sec_tens;
            sec_tens    <= sec_ones;
            sec_ones    <= key_digit;
            digit_count <= (digit_count == 2'd3) ? 2'd3 : digit_count + 2'd1;
            state       <= ENTRY;
          end
        end
        ENTRY: begin
          if (key_cancel) begin
            sec_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            min_ones    <= 4'd0;
            digit_count <= 2'd0;
            state       <= IDLE;
          end else if (digit_ok) begin
            min_ones    <= sec_tens;
            sec_tens    <= sec_ones;
            sec_ones    <= key_digit;
            digit_count <= (digit_count == 2'd3) ? 2'd3 : digit_count + 2'd1;
          end else if (start_req) begin
            if (tens_ok && nonzero) begin
              load     <= 1'b0;
              load_cnt <= 2'd0;
              state    <= LOAD;
`ifdef TIMER_NORMALIZE_EN
            end else if (!tens_ok && (min_ones < 4'd9)) begin
              sec_tens <= sec_tens - (MAX_TENS + 4'd1);
              min_ones <= min_ones + 4'd1;
              load     <= 1'b0;
              load_cnt <= 2'd0;
              state    <= LOAD;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (load_cnt == 2'(LOAD_CYCLES - 1)) begin
            load   <= 1'b1;
            loaded <= 1'b1;
            state  <= DONE;
          end else begin
            load_cnt <= load_cnt + 2'd1;
          end
        end
        DONE: begin
          // Digits stay visible through this cycle so the counters latch cleanly.
          sec_ones    <= 4'd0;
          sec_tens    <= 4'd0;
          min_ones    <= 4'd0;
          digit_count <= 2'd0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_digit_loader.sv
// tb/tb_timer_digit_loader.sv - self-checking bench for timer_digit_loader
module tb_timer_digit_loader;
  localparam int LC = 1;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_cancel = 1'b0;
  logic       key_start = 1'b0;
  logic       timer_running = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       load, loaded, err;
  logic [1:0] digit_count;

  int n_checks = 0;
  int n_fail = 0;

  // Model: list of accepted digits; the display is the last three of them.
  int m_q[$];

  always #5 clk = ~clk;

  timer_digit_loader #(.MAX_TENS(4'd5), .LOAD_CYCLES(LC)) dut (
    .clk(clk), .clear(clear), .key_valid(key_valid), .key_digit(key_digit),
    .key_cancel(key_cancel), .key_start(key_start), .timer_running(timer_running),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .load(load),
    .digit_count(digit_count), .loaded(loaded), .err(err)
  );

  function automatic int m_digit(input int pos);
    if (m_q.size() > pos) return m_q[m_q.size() - 1 - pos];
    return 0;
  endfunction

  function automatic int m_count();
    return (m_q.size() > 3) ? 3 : m_q.size();
  endfunction

  task automatic key(input logic [3:0] d);
    @(negedge clk); key_valid = 1'b1; key_digit = d;
    @(negedge clk); key_valid = 1'b0;
    if (d <= 4'd9 && !timer_running) m_q.push_back(int'(d));
  endtask

  task automatic press_start();
    @(negedge clk); key_start = 1'b1;
    @(negedge clk); key_start = 1'b0;
  endtask

  task automatic press_cancel();
    @(negedge clk); key_cancel = 1'b1;
    @(negedge clk); key_cancel = 1'b0;
    m_q.delete();
  endtask

  task automatic check_digits(input string name, input int mo, input int st, input int so, input int cnt);
    n_checks++;
    if (min_ones !== 4'(mo) || sec_tens !== 4'(st) || sec_ones !== 4'(so) || digit_count !== 2'(cnt)) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d%0d cnt=%0d, expected %0d:%0d%0d cnt=%0d", name,
               min_ones, sec_tens, sec_ones, digit_count, mo, st, so, cnt);
    end
  endtask

  // Called right after the start edge of an accepted load.
  task automatic finish_load(input string name, input int mo, input int st, input int so);
    for (int i = 0; i < LC; i++) begin
      n_checks++;
      if (load !== 1'b0 || loaded !== 1'b0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_low: load=%b loaded=%b err=%b, expected 0 0 0", name, load, loaded, err);
      end
      check_digits({name, "_frozen"}, mo, st, so, m_count());
      if (i < LC - 1) @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (load !== 1'b1 || loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: load=%b loaded=%b, expected 1 1", name, load, loaded);
    end
    check_digits({name, "_done_hold"}, mo, st, so, m_count());
    @(negedge clk);
    m_q.delete();
    n_checks++;
    if (loaded !== 1'b0 || load !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_after: loaded=%b load=%b, expected 0 1", name, loaded, load);
    end
    check_digits({name, "_cleared"}, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    clear = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (load !== 1'b1 || loaded !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: load=%b loaded=%b err=%b, expected 1 0 0", load, loaded, err);
    end
    check_digits("reset_digits", 0, 0, 0, 0);
    clear = 1'b1;
    m_q.delete();
  endtask

  task automatic test_load_basic();
    key(4'd1); key(4'd3); key(4'd0);
    check_digits("basic_entry", 1, 3, 0, 3);
    press_start();
    finish_load("basic", 1, 3, 0);
  endtask

  task automatic test_overflow();
    key(4'd2); key(4'd4); key(4'd5); key(4'd9);
    check_digits("overflow_entry", 4, 5, 9, 3);
    press_start();
    finish_load("overflow", 4, 5, 9);
  endtask

  task automatic test_tens_reject();
    key(4'd7); key(4'd5);
    press_start();
`ifdef TIMER_NORMALIZE_EN
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL norm_err: err=%b, expected 0", err);
    end
    finish_load("norm", 1, 1, 5);
`else
    n_checks++;
    if (err !== 1'b1 || load !== 1'b1) begin
      n_fail++;
      $display("FAIL reject_err: err=%b load=%b, expected 1 1", err, load);
    end
    check_digits("reject_kept", 0, 7, 5, 2);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || load !== 1'b1) begin
      n_fail++;
      $display("FAIL reject_pulse: err=%b load=%b, expected 0 1", err, load);
    end
    press_cancel();
`endif
  endtask

  task automatic test_cancel_priority();
    key(4'd3);
    @(negedge clk); key_valid = 1'b1; key_digit = 4'd4; key_cancel = 1'b1;
    @(negedge clk); key_valid = 1'b0; key_cancel = 1'b0;
    m_q.delete();
    check_digits("cancel_prio", 0, 0, 0, 0);
    key(4'd12);
    check_digits("bad_digit_idle", 0, 0, 0, 0);
    key(4'd3); key(4'd12);
    check_digits("bad_digit_entry", 0, 0, 3, 1);
    // Start alongside a digit is dropped, not queued.
    @(negedge clk); key_valid = 1'b1; key_digit = 4'd2; key_start = 1'b1;
    @(negedge clk); key_valid = 1'b0; key_start = 1'b0;
    m_q.push_back(2);
    n_checks++;
    if (load !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_with_digit: load=%b err=%b, expected 1 0", load, err);
    end
    check_digits("start_with_digit_d", 0, 3, 2, 2);
    @(negedge clk);
    n_checks++;
    if (load !== 1'b1) begin
      n_fail++;
      $display("FAIL start_not_queued: load=%b, expected 1", load);
    end
    press_cancel();
  endtask

  task automatic test_running();
    key(4'd6);
    timer_running = 1'b1;
    key(4'd4);
    press_start();
    n_checks++;
    if (load !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL running_start: load=%b err=%b, expected 1 0", load, err);
    end
    check_digits("running_digit", 0, 0, 6, 1);
    press_cancel();
    check_digits("running_cancel", 0, 0, 0, 0);
    timer_running = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    bit saw_loaded = 1'b0;
    key(4'd1);
    press_start();
    n_checks++;
    if (load !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_low: load=%b, expected 0", load);
    end
    #1 clear = 1'b0;
    #1;
    n_checks++;
    if (load !== 1'b1) begin
      n_fail++;
      $display("FAIL midload_async: load=%b, expected 1", load);
    end
    check_digits("midload_clear", 0, 0, 0, 0);
    m_q.delete();
    @(negedge clk); clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (loaded) saw_loaded = 1'b1;
    end
    n_checks++;
    if (saw_loaded) begin
      n_fail++;
      $display("FAIL midload_loaded: loaded pulsed=1, expected 0");
    end
    key(4'd0);
    press_start();
    n_checks++;
    if (err !== 1'b1 || load !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_reject: err=%b load=%b, expected 1 1", err, load);
    end
    press_cancel();
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int nk = $urandom_range(1, 5);
      int mo, st, so;
      bit accept, norm;
      for (int k = 0; k < nk; k++) key(4'($urandom_range(0, 15)));
      mo = m_digit(2); st = m_digit(1); so = m_digit(0);
      check_digits("rand_entry", mo, st, so, m_count());
      press_start();
      accept = (m_q.size() > 0) && (st <= 5) && ((mo + st + so) != 0);
      norm = 1'b0;
`ifdef TIMER_NORMALIZE_EN
      if (m_q.size() > 0 && st > 5 && mo < 9) begin
        accept = 1'b1; norm = 1'b1;
      end
`endif
      if (accept) begin
        finish_load("rand_load", norm ? mo + 1 : mo, norm ? st - 6 : st, so);
      end else begin
        n_checks++;
        if (load !== 1'b1 || err !== ((m_q.size() > 0) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL rand_reject: load=%b err=%b, expected 1 %b", load, err, m_q.size() > 0);
        end
        press_cancel();
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_overflow();
    test_tens_reject();
    test_cancel_priority();
    test_running();
    test_reset_mid_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
